// File: rtl/ternary_window_gen.sv
// ternary_window_gen: buffers two lines of 2-bit ternary pixels and emits packed 3x3 "valid" windows; define TERNARY_PIX_CHECK_EN to add o_err illegal-pixel detection
module ternary_window_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [1:0]  s_data,
  input  logic        s_sof,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [17:0] o_window,
  output logic        o_last,
  output logic        o_frame_done
`ifdef TERNARY_PIX_CHECK_EN
  ,
  output logic        o_err
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
  state_t state, state_d;
  logic [CW-1:0] col, pc, nc;
  logic [RW-1:0] row, pr, nr;
  logic [1:0] lb0 [IMG_W];
  logic [1:0] lb1 [IMG_W];
  logic [5:0] wc1, wc2, new_col;
  logic [1:0] pix;
  logic accept, at_last, win;
  assign s_ready = !o_valid || o_ready;
  assign accept = s_valid && s_ready;
  assign pc = s_sof ? '0 : col;
  assign pr = s_sof ? '0 : row;
  assign at_last = (pr == R_LAST) && (pc == C_LAST);
  assign win = (pr >= RW'(2)) && (pc >= CW'(2));
  assign nc = (pc == C_LAST) ? '0 : pc + 1'b1;
  assign nr = (pc == C_LAST) ? ((pr == R_LAST) ? '0 : pr + 1'b1) : pr;
`ifdef TERNARY_PIX_CHECK_EN
  assign pix = (s_data == 2'b10) ? 2'b00 : s_data;
`else
  assign pix = s_data;
`endif
  // bottom pixel in the high bits so the column drops straight into the packed window
  assign new_col = {pix, lb0[pc], lb1[pc]};
  // frame phase tracking: fill the first two lines, stream windows, idle after the last pixel
  always_comb begin
    state_d = state;
    if (accept)
      state_d = (s_sof || state == IDLE) ? FILL :
                (state == FILL && nr == RW'(2)) ? STREAM :
                (state == STREAM && at_last) ? IDLE : state;
  end
  // position counters, FSM and output handshake registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      o_valid      <= 1'b0;
      o_last       <= 1'b0;
      o_frame_done <= 1'b0;
      o_window     <= '0;
    end else begin
      state        <= state_d;
      o_frame_done <= accept && at_last;
      if (accept) begin
        row <= nr;
        col <= nc;
      end
      if (accept && win) begin
        o_valid  <= 1'b1;
        o_window <= {new_col, wc2, wc1};
        o_last   <= at_last;
      end else if (o_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
    end
  end
  // line buffers and window columns carry no reset; they are refilled before use
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[pc] <= lb0[pc];
      lb0[pc] <= pix;
      wc1     <= wc2;
      wc2     <= new_col;
    end
  end
`ifdef TERNARY_PIX_CHECK_EN
  // sticky flag for any accepted illegal 2'b10 pixel
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) o_err <= 1'b0;
    else if (accept && s_data == 2'b10) o_err <= 1'b1;
  end
`endif
endmodule

// File: doc/ternary_window_gen.md
Name: ternary_window_gen

Overview:
- Upstream feeder for the 3x3 ternary convolution stage.
- Accepts a raster-order stream of 2-bit ternary pixels, buffers two image lines, and emits one packed 18-bit 3x3 window per valid ("valid"-mode, no padding) output position.
- Output packing matches the convolution's i_data layout, so o_window connects to it directly.

Parameters:
- IMG_W, 28, pixels per line (>=3).
- IMG_H, 28, lines per frame (>=3).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input pixel accepted when s_valid && s_ready.
- s_data  in  2  ternary pixel: 01=+1, 11=-1, 00=0; 10 is illegal.
- s_sof  in  1  start of frame, qualified by accept.
- o_valid  out  1  window valid.
- o_ready  in  1  downstream ready.
- o_window  out  18  packed 3x3 window.
- o_last  out  1  last window of the frame, qualified by o_valid.
- o_frame_done  out  1  one-cycle pulse after the frame's final pixel is accepted.

Behaviour:
- Reset: asynchronous, active-low. Clears these to 0: o_valid, o_last, o_frame_done, o_window, the row/col counters, and the FSM (state IDLE). Line buffers and window registers are not reset; their contents are don't-care until refilled.
- Accept and handshake:
  - s_ready = !o_valid || o_ready (combinational).
  - o_valid/o_window/o_last are held stable while o_valid && !o_ready.
  - On (o_valid && o_ready) with no new window generated, o_valid -> 0.
- Position counters: col 0..IMG_W-1, row 0..IMG_H-1.
  - Each accept advances col; at IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0.
  - An accept with s_sof=1 treats the pixel as (0,0), whatever the counters hold. The counters then become (0,1), abandoning any partial frame with no output for it.
- Storage on accept at column c:
  - lb1[c] <= lb0[c]; lb0[c] <= pixel. Each line buffer is IMG_W x 2 bits.
  - Window columns shift left (col0 <= col1, col1 <= col2).
  - New col2 = {top: lb1[c], mid: lb0[c], bottom: pixel}, using the pre-update line-buffer values.
- Window generation: an accept at (r, c) with r>=2 and c>=2 loads o_window and sets o_valid=1 on the next edge (latency 1 cycle).
  - Window content is rows r-2..r, cols c-2..c.
  - o_last=1 iff (r, c) = (IMG_H-1, IMG_W-1).
  - 26x26 windows per frame at defaults.
- Packing: window pixel p(wr, wc), wr=0 top and wc=0 left, occupies o_window[2k+1:2k] with k = 3*wc + wr (column-major). Bits [5:0] hold the left column, bottom pixel at [5:4].
- FSM:
  - IDLE -> FILL on the first accept.
  - FILL (row<2) -> STREAM when row reaches 2.
  - STREAM -> IDLE on accepting (IMG_H-1, IMG_W-1); o_frame_done pulses the next cycle.
  - An s_sof accept from any state -> FILL.
- Line wrap: the first two columns of each row >=2 produce no window. The window registers are refilled by those two accepts, so no stale cross-line data is ever emitted.
- Simultaneous output drain and new window in the same cycle: o_valid stays 1 with the new data. No bubble.

Optional Feature:
- Macro: TERNARY_PIX_CHECK_EN.
- Defined:
  - Adds output port o_err (1 bit, reset 0).
  - An accepted s_data==2'b10 sets o_err sticky until resetn, and the pixel is stored as 2'b00.
- Undefined:
  - No o_err port.
  - 2'b10 is stored unchanged, and downstream behaviour is unspecified.

Test Plan:
- IMG_W=IMG_H=4, all pixels 01, o_ready=1 -> exactly 4 windows, each 18'h15555; o_last only on the 4th; o_frame_done pulses once, 1 cycle after the 16th accept.
- IMG_W=IMG_H=4, pixel (0,0)=01 else 00 -> first window 18'h00001, other three 18'h00000. Repeat with only (2,2)=01 -> first window 18'h10000.
- o_ready held low for 5 cycles while windows pend -> s_ready=0, o_window/o_valid unchanged across the stall; no pixel lost; window sequence matches the no-stall run.
- Mid-frame s_sof (after 9 pixels of a 4x4 frame), then 16 pixels all 11 -> exactly 4 windows of 18'h3FFFF; no window is formed from the abandoned pixels.
- resetn pulsed low mid-frame (async, between edges) -> o_valid=0 immediately; the next full frame produces the correct 4 windows.
- TERNARY_PIX_CHECK_EN defined, one 2'b10 pixel at (2,2) in an all-01 4x4 frame -> o_err=1 and stays 1; first window = 18'h05555 (bits [17:16]=00).
